// File: rtl/var_delay_line_if.sv
// Stream bundle for var_delay_line: accepted input word in, delayed word out.
// No latency of its own; wires only.
// No backpressure: din_valid is a pure qualifier and dout_valid is a one-cycle pulse.
interface var_delay_line_if #(
  parameter int WIDTH = 16
);
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             dout_valid;
  logic [WIDTH-1:0] dout;

  // Producer/consumer side (drives input words, observes delayed words)
  modport master (
    output din_valid, din,
    input  dout_valid, dout
  );

  // Delay line side
  modport slave (
    input  din_valid, din,
    output dout_valid, dout
  );
endinterface

// File: rtl/var_delay_line.sv
// Sample-indexed delay line: delays each accepted word by 0..MAX_STAGES accepted samples.
// Latency: dout/dout_valid register on the accept edge (1 clock); sample-domain delay D.
// Backpressure: none; accepts one word per clock whenever din_valid is high.
module var_delay_line #(
  parameter  int WIDTH      = 16,
  parameter  int MAX_STAGES = 8,
  localparam int DW         = $clog2(MAX_STAGES + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                flush,
  input  logic [DW-1:0]       delay,
  var_delay_line_if.slave     bus,
  output logic [DW-1:0]       fill,
  output logic                delay_err
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_STAGES);

  logic [WIDTH-1:0] stage [MAX_STAGES];
  logic [DW-1:0]    d_eff;
  logic             out_of_range;
  logic [WIDTH-1:0] tap;
  logic [WIDTH-1:0] sel_word;
  logic             sel_ok;

  // Clamp the requested delay to the chain depth; oversize requests behave as the maximum
  always_comb begin
    out_of_range = (delay > MAX_D);
    d_eff        = out_of_range ? MAX_D : delay;
  end

  // Pick the pre-shift tap D samples back; D=0 bypasses the chain with the live input
  always_comb begin
    tap = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (d_eff == DW'(i + 1)) begin
        tap = stage[i];
      end
    end
    sel_word = (d_eff == '0) ? bus.din : tap;
    sel_ok   = (d_eff == '0) || (fill >= d_eff);
  end

  // History chain: shifts only on accepted samples, cleared by flush
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < MAX_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < MAX_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else if (bus.din_valid) begin
      stage[0] <= bus.din;
      for (int i = 1; i < MAX_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Fill level: counts accepted samples, saturating once the chain is full
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (bus.din_valid && (fill != MAX_D)) begin
      fill <= fill + DW'(1);
    end
  end

  // Output register: pulse only when enough history exists for the effective delay
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
    end else if (flush) begin
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= bus.din_valid && sel_ok;
      if (bus.din_valid && sel_ok) begin
        bus.dout <= sel_word;
      end
    end
  end

  // Sticky out-of-range flag; returning the delay in range does not clear it
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      delay_err <= 1'b0;
    end else if (flush) begin
      delay_err <= 1'b0;
    end else if (out_of_range) begin
      delay_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: directed scenarios plus random traffic against a queue model.
// Expected words are queued at the accept edge and popped by a monitor on output pulses.
// The DUT has no backpressure, so stimulus runs on a fixed cycle schedule.
module tb_var_delay_line;
  localparam int WIDTH = 16;
  localparam int MAX   = 8;
  localparam int DW    = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          arst_n;
  logic          flush;
  logic [DW-1:0] delay;
  logic [DW-1:0] fill;
  logic          delay_err;

  always #5 clk = ~clk;

  var_delay_line_if #(.WIDTH(WIDTH)) sif ();

  var_delay_line #(.WIDTH(WIDTH), .MAX_STAGES(MAX)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .delay     (delay),
    .bus       (sif),
    .fill      (fill),
    .delay_err (delay_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: hist[0] is the most recent accepted sample
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] expq [$];
  logic             exp_vld;
  logic             exp_err;
  logic [WIDTH-1:0] exp_dout;
  int               exp_fill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    expq.delete();
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    exp_dout = '0;
    exp_fill = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs present at that edge
  task automatic model_edge(input bit vld, input logic [WIDTH-1:0] d, input int dl, input bit fl);
    int eff;
    if (fl) begin
      hist.delete();
      exp_vld = 1'b0;
      exp_err = 1'b0;
    end else begin
      if (dl > MAX) exp_err = 1'b1;
      eff     = (dl > MAX) ? MAX : dl;
      exp_vld = 1'b0;
      if (vld) begin
        if (eff == 0) begin
          exp_dout = d;
          exp_vld  = 1'b1;
        end else if (hist.size() >= eff) begin
          exp_dout = hist[eff-1];
          exp_vld  = 1'b1;
        end
        if (exp_vld) expq.push_back(exp_dout);
        hist.push_front(d);
        if (hist.size() > MAX) void'(hist.pop_back());
      end
    end
    exp_fill = hist.size();
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  task automatic cyc(input bit vld, input logic [WIDTH-1:0] d, input int dl, input bit fl);
    sif.din_valid = vld;
    sif.din       = d;
    delay         = DW'(dl);
    flush         = fl;
    @(posedge clk);
    if (arst_n) model_edge(vld, d, dl, fl);
    #2;
  endtask

  // Monitor: compares every cycle on the falling edge, popping the scoreboard on pulses
  initial begin
    forever begin
      @(negedge clk);
      check("dout_valid", 32'(sif.dout_valid), 32'(exp_vld));
      if (sif.dout_valid) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dout_unexpected: got pulse with %0h, expected no pending word at %0t",
                   sif.dout, $time);
        end else begin
          check("dout_word", 32'(sif.dout), 32'(expq.pop_front()));
        end
      end
      check("dout_hold", 32'(sif.dout), 32'(exp_dout));
      check("fill", 32'(fill), 32'(exp_fill));
      check("delay_err", 32'(delay_err), 32'(exp_err));
    end
  end

  initial begin
    int dl;
    arst_n        = 1'b0;
    flush         = 1'b0;
    delay         = '0;
    sif.din_valid = 1'b0;
    sif.din       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    arst_n = 1'b1;

    // Reset / idle
    repeat (5) cyc(0, '0, 0, 0);

    // Fill and steady state with delay 3
    for (int i = 1; i <= 12; i++) cyc(1, WIDTH'(i), 3, 0);

    // Gapped input with D=0
    cyc(0, '0, 0, 1);
    cyc(1, 16'h000A, 0, 0);
    cyc(0, '0, 0, 0);
    cyc(1, 16'h000B, 0, 0);
    cyc(1, 16'h000C, 0, 0);
    cyc(0, '0, 0, 0);

    // Delay change while streaming, then a longer delay after flush
    for (int i = 0; i < 10; i++) cyc(1, WIDTH'(16'h0100 + i), 5, 0);
    for (int i = 0; i < 4; i++)  cyc(1, WIDTH'(16'h0200 + i), 2, 0);
    cyc(0, '0, 2, 1);
    for (int i = 0; i < 8; i++)  cyc(1, WIDTH'(16'h0300 + i), 6, 0);

    // Out of range: idle edge sets the flag, then behaves as max delay, flag is sticky
    cyc(0, '0, 15, 0);
    for (int i = 0; i < 10; i++) cyc(1, WIDTH'(16'h0400 + i), 12, 0);
    for (int i = 0; i < 4; i++)  cyc(1, WIDTH'(16'h0410 + i), 3, 0);
    cyc(0, '0, 3, 1);
    cyc(0, '0, 3, 0);

    // Flush together with an accept drops the sample
    cyc(1, 16'h0500, 0, 0);
    cyc(1, 16'h0501, 0, 1);
    cyc(1, 16'h0502, 2, 0);
    cyc(1, 16'h0503, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) dl = $urandom_range(9, 15);
      else                            dl = $urandom_range(0, MAX);
      cyc($urandom_range(0, 3) != 0, WIDTH'($urandom), dl, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset mid-stream, between clock edges
    for (int i = 0; i < 5; i++) cyc(1, WIDTH'(16'h0600 + i), 1, 0);
    arst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(sif.dout), 32'h0);
    check("async_rst_vld", 32'(sif.dout_valid), 32'h0);
    check("async_rst_fill", 32'(fill), 32'h0);
    check("async_rst_err", 32'(delay_err), 32'h0);
    model_reset();
    #1;
    cyc(1, 16'h0700, 0, 0);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, WIDTH'(16'h0800 + i), 2, 0);
    repeat (2) cyc(0, '0, 2, 0);

    check("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
